// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction-memory
// address and captures the fetched word into the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_FLUSH,
        MODE_HOLD,
        MODE_ADVANCE
    } mode_t;

    // Sequential PC increment; wraps modulo 2^32 with no carry out.
    function automatic logic [31:0] pc_add4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    // Instructions are word aligned, so the two low address bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    mode_t       mode;
    logic [31:0] pc_p0;
    logic [31:0] pc4_p0;
    logic [31:0] target_p0;

    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;

    assign pc4_p0    = pc_add4(pc_p0);
    assign target_p0 = word_align(redirect_pc);
    assign imem_addr = pc_p0;
    assign pc        = pc_p0;

    // Redirect outranks stall so a wrong-path fetch is squashed even while decode is held.
    always_comb begin
        mode = MODE_ADVANCE;
        if (rst) begin
            mode = MODE_RESET;
        end else if (redirect) begin
            mode = MODE_FLUSH;
        end else if (stall) begin
            mode = MODE_HOLD;
        end
    end

    // ---- p0 -> p1: PC update and IF/ID capture ----
    always_ff @(posedge clk) begin
        case (mode)
            MODE_RESET: begin
                pc_p0    <= word_align(RESET_PC);
                instr_p1 <= NOP_INSTR;
                pc_p1    <= 32'd0;
                pc4_p1   <= 32'd0;
                vld_p1   <= 1'b0;
            end
            MODE_FLUSH: begin
                pc_p0    <= target_p0;
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end
            MODE_HOLD: begin
                pc_p0    <= pc_p0;
                instr_p1 <= instr_p1;
                pc_p1    <= pc_p1;
                pc4_p1   <= pc4_p1;
                vld_p1   <= vld_p1;
            end
            default: begin
                pc_p0    <= pc4_p0;
                instr_p1 <= imem_data;
                pc_p1    <= pc_p0;
                pc4_p1   <= pc4_p0;
                vld_p1   <= 1'b1;
            end
        endcase
    end

    assign if_id_instr = instr_p1;
    assign if_id_pc    = pc_p1;
    assign if_id_pc4   = pc4_p1;
    assign if_id_valid = vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected post-edge state into
// a queue as each cycle's inputs are driven; results are popped and compared after the edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        vld;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_mis = 0;

    exp_t sb[$];
    exp_t m;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid),
        .pc         (pc)
    );

    // Memory image: word i (address 4*i) holds 32'h1000_0000 + i.
    assign imem_data = 32'h1000_0000 + (imem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, applied to the model state m.
    task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        exp_t n;
        n = m;
        if (r) begin
            n.pc = 32'h0; n.instr = NOP; n.ipc = 32'h0; n.ipc4 = 32'h0; n.vld = 1'b0;
        end else if (rd) begin
            n.pc = {rpc[31:2], 2'b00}; n.instr = NOP; n.vld = 1'b0;
        end else if (!s) begin
            n.instr = mem_word(m.pc);
            n.ipc   = m.pc;
            n.ipc4  = m.pc + 32'd4;
            n.pc    = m.pc + 32'd4;
            n.vld   = 1'b1;
        end
        m = n;
    endtask

    // Drive one cycle, push expectation, wait for the edge, pop and compare everything.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        model_edge(r, s, rd, rpc);
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_imem_addr", imem_addr, e.pc);
        check("sb_vld", {31'd0, if_id_valid}, {31'd0, e.vld});
        check("sb_instr", if_id_instr, e.instr);
        check("sb_ipc", if_id_pc, e.ipc);
        check("sb_ipc4", if_id_pc4, e.ipc4);
    endtask

    task automatic expect_now(input string tag, input logic [31:0] epc, input logic [31:0] einstr,
                              input logic [31:0] eipc, input logic [31:0] eipc4, input logic evld);
        check({tag, "_pc"}, pc, epc);
        check({tag, "_instr"}, if_id_instr, einstr);
        check({tag, "_ipc"}, if_id_pc, eipc);
        check({tag, "_ipc4"}, if_id_pc4, eipc4);
        check({tag, "_vld"}, {31'd0, if_id_valid}, {31'd0, evld});
    endtask

    initial begin
        m = '{pc: 32'h0, instr: NOP, ipc: 32'h0, ipc4: 32'h0, vld: 1'b0};
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset for two cycles, then sequential fetch.
        step(1, 0, 0, 32'h0);
        expect_now("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        expect_now("seq0", 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1);
        step(0, 0, 0, 32'h0);
        expect_now("seq1", 32'h8, 32'h1000_0001, 32'h4, 32'h8, 1'b1);

        // Stall for three cycles at pc=8.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0);
            expect_now("stall", 32'h8, 32'h1000_0001, 32'h4, 32'h8, 1'b1);
        end
        step(0, 0, 0, 32'h0);
        expect_now("resume", 32'hC, 32'h1000_0002, 32'h8, 32'hC, 1'b1);
        step(0, 0, 0, 32'h0);
        expect_now("seq3", 32'h10, 32'h1000_0003, 32'hC, 32'h10, 1'b1);

        // Taken branch at pc=16 to 0x40.
        step(0, 0, 1, 32'h0000_0040);
        expect_now("branch", 32'h40, NOP, 32'hC, 32'h10, 1'b0);
        step(0, 0, 0, 32'h0);
        expect_now("target", 32'h44, 32'h1000_0010, 32'h40, 32'h44, 1'b1);

        // Redirect and stall together with a misaligned target; redirect wins.
        step(0, 1, 1, 32'h0000_0083);
        expect_now("rd_vs_stall", 32'h80, NOP, 32'h40, 32'h44, 1'b0);
        step(0, 1, 0, 32'h0);
        expect_now("hold_after_rd", 32'h80, NOP, 32'h40, 32'h44, 1'b0);

        // Redirect held for two cycles gives two bubbles, last target wins.
        step(0, 0, 1, 32'h0000_0100);
        step(0, 0, 1, 32'h0000_0200);
        expect_now("rd_twice", 32'h200, NOP, 32'h40, 32'h44, 1'b0);
        step(0, 0, 0, 32'h0);
        expect_now("rd_twice_tgt", 32'h204, 32'h1000_0080, 32'h200, 32'h204, 1'b1);

        // Wrap-around of the PC.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        expect_now("wrap", 32'h0, 32'h4FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1);
        step(0, 0, 0, 32'h0);
        expect_now("wrap_next", 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1);

        // Mid-operation reset while stalled with a valid instruction at pc=40.
        step(0, 0, 1, 32'h0000_0024);
        step(0, 0, 0, 32'h0);
        expect_now("pre_rst", 32'h28, 32'h1000_0009, 32'h24, 32'h28, 1'b1);
        step(0, 1, 0, 32'h0);
        step(1, 1, 1, 32'h0000_0300);
        expect_now("mid_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        step(0, 0, 0, 32'h0);
        expect_now("post_rst", 32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1);

        // Mixed random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), $urandom);
        end

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
